// File: rtl/anomaly_report_tx.sv
// Serial transmitter for anomaly reports: frames {start, flag, data LSB-first, [parity], stop}.
// Optional even-parity bit enabled by defining ANOMALY_TX_PARITY_EN.
module anomaly_report_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  anomaly_flag,
  input  logic                  report_valid,
  output logic                  report_accepted,
  output logic                  serial_out,
  output logic                  tx_busy
);

  localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_FLAG   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef ANOMALY_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  flag_q, flag_d;
`ifdef ANOMALY_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  serial_out_q, serial_out_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  report_accepted_q, report_accepted_d;
  logic                  bit_end;

  // Next-state logic; outputs are computed from the next state so they are registered.
  always_comb begin
    state_d           = state_q;
    cyc_d             = cyc_q;
    bit_d             = bit_q;
    shift_d           = shift_q;
    flag_d            = flag_q;
`ifdef ANOMALY_TX_PARITY_EN
    parity_d          = parity_q;
`endif
    bit_end           = (cyc_q == CYC_LAST);
    report_accepted_d = 1'b0;

    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + CYC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (report_valid) begin
          shift_d           = data_input;
          flag_d            = anomaly_flag;
`ifdef ANOMALY_TX_PARITY_EN
          parity_d          = ^{anomaly_flag, data_input};
`endif
          cyc_d             = '0;
          bit_d             = '0;
          report_accepted_d = 1'b1;
          state_d           = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_FLAG;
      S_FLAG: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef ANOMALY_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef ANOMALY_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP: if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  serial_out_d = 1'b0;
      S_FLAG:   serial_out_d = flag_d;
      S_DATA:   serial_out_d = shift_d[0];
`ifdef ANOMALY_TX_PARITY_EN
      S_PARITY: serial_out_d = parity_d;
`endif
      default:  serial_out_d = 1'b1;
    endcase
    tx_busy_d = (state_d != S_IDLE);
  end

  // Reset aborts any frame in flight and forces the line idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      cyc_q             <= '0;
      bit_q             <= '0;
      shift_q           <= '0;
      flag_q            <= 1'b0;
`ifdef ANOMALY_TX_PARITY_EN
      parity_q          <= 1'b0;
`endif
      serial_out_q      <= 1'b1;
      tx_busy_q         <= 1'b0;
      report_accepted_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      cyc_q             <= cyc_d;
      bit_q             <= bit_d;
      shift_q           <= shift_d;
      flag_q            <= flag_d;
`ifdef ANOMALY_TX_PARITY_EN
      parity_q          <= parity_d;
`endif
      serial_out_q      <= serial_out_d;
      tx_busy_q         <= tx_busy_d;
      report_accepted_q <= report_accepted_d;
    end
  end

  assign report_accepted = report_accepted_q;
  assign serial_out      = serial_out_q;
  assign tx_busy         = tx_busy_q;

endmodule

// File: tb/tb_anomaly_report_tx.sv
// Self-checking bench for anomaly_report_tx; expected frames come from a bit-list model.
// Honours ANOMALY_TX_PARITY_EN the same way as the design.
module tb_anomaly_report_tx;

  localparam int DW = 8;
  localparam int BC = 4;
`ifdef ANOMALY_TX_PARITY_EN
  localparam int NBITS = DW + 4;
`else
  localparam int NBITS = DW + 3;
`endif
  localparam int FRAME = NBITS * BC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_input = '0;
  logic          anomaly_flag = 1'b0;
  logic          report_valid = 1'b0;
  logic          report_accepted;
  logic          serial_out;
  logic          tx_busy;

  int tests = 0;
  int fails = 0;

  anomaly_report_tx #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_input      (data_input),
    .anomaly_flag    (anomaly_flag),
    .report_valid    (report_valid),
    .report_accepted (report_accepted),
    .serial_out      (serial_out),
    .tx_busy         (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame bit idx of a report: start, flag, data LSB first, optional parity, stop.
  function automatic logic exp_bit(input logic [DW-1:0] d, input logic f, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 1) return f;
    if (idx < DW + 2) return d[idx-2];
`ifdef ANOMALY_TX_PARITY_EN
    if (idx == DW + 2) return ($countones({f, d}) % 2) == 1;
`endif
    return 1'b1;
  endfunction

  // Waits (bounded) for the acceptance pulse; idle cycles before it must show an idle line.
  task automatic wait_accept(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!report_accepted) begin
        tests++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b0) begin
          fails++;
          $display("FAIL %s idle_line: serial_out=%b tx_busy=%b, required 1/0", name, serial_out, tx_busy);
        end
      end
    end while (report_accepted !== 1'b1 && n < 200);
    tests++;
    if (report_accepted !== 1'b1) begin
      fails++;
      $display("FAIL %s accept_timeout: report_accepted=%b after %0d cycles, required 1", name, report_accepted, n);
    end
  endtask

  // Called on the acceptance cycle; checks every cycle of the frame against the model.
  task automatic check_frame(input string name, input logic [DW-1:0] d, input logic f,
                             input int drop_at, input int change_at,
                             input logic [DW-1:0] new_d, input logic new_f, input logic new_v);
    for (int k = 0; k < FRAME; k++) begin
      if (k != 0) @(negedge clk);
      tests++;
      if (serial_out !== exp_bit(d, f, k / BC) || tx_busy !== 1'b1 ||
          report_accepted !== (k == 0)) begin
        fails++;
        $display("FAIL %s cycle %0d: serial_out=%b tx_busy=%b accepted=%b, required %b/1/%b",
                 name, k, serial_out, tx_busy, report_accepted, exp_bit(d, f, k / BC), (k == 0));
      end
      if (k == change_at) begin
        data_input   = new_d;
        anomaly_flag = new_f;
        report_valid = new_v;
      end
      if (k == drop_at) report_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    tests++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0 || report_accepted !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: serial_out=%b tx_busy=%b accepted=%b, required 1/0/0",
               name, serial_out, tx_busy, report_accepted);
    end
  endtask

  task automatic send(input string name, input logic [DW-1:0] d, input logic f);
    int n;
    data_input   = d;
    anomaly_flag = f;
    report_valid = 1'b1;
    wait_accept(name, n);
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL %s accept_latency: %0d cycles, required 1", name, n);
    end
    check_frame(name, d, f, 0, -1, '0, 1'b0, 1'b0);
    check_idle(name);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    report_valid = 1'b1;
    data_input   = DW'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (serial_out !== 1'b1 || tx_busy !== 1'b0 || report_accepted !== 1'b0) begin
        fails++;
        $display("FAIL reset cycle %0d: serial_out=%b tx_busy=%b accepted=%b, required 1/0/0",
                 i, serial_out, tx_busy, report_accepted);
      end
    end
    report_valid = 1'b0;
    reset        = 1'b0;
    check_idle("reset_release");
    check_idle("reset_release2");
  endtask

  task automatic test_single();
    send("single_a5", 8'hA5, 1'b1);
    send("single_a5_f0", 8'hA5, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    data_input   = 8'h3C;
    anomaly_flag = 1'b0;
    report_valid = 1'b1;
    wait_accept("b2b1", n);
    check_frame("b2b1", 8'h3C, 1'b0, -1, 1, 8'hFF, 1'b1, 1'b1);
    wait_accept("b2b2", n);
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL b2b_gap: next accept %0d cycles after frame end, required 2", n);
    end
    check_frame("b2b2", 8'hFF, 1'b1, 0, -1, '0, 1'b0, 1'b0);
    check_idle("b2b_end");
  endtask

  task automatic test_input_change();
    int n;
    data_input   = 8'h0F;
    anomaly_flag = 1'b0;
    report_valid = 1'b1;
    wait_accept("change", n);
    check_frame("change", 8'h0F, 1'b0, 0, 10, 8'hF0, 1'b1, 1'b0);
    check_idle("change_end");
  endtask

  task automatic test_withdraw();
    int n;
    data_input   = 8'h81;
    anomaly_flag = 1'b1;
    report_valid = 1'b1;
    wait_accept("withdraw", n);
    check_frame("withdraw", 8'h81, 1'b1, 20, 5, 8'h42, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) check_idle("withdraw_none");
  endtask

  task automatic test_reset_mid();
    int n;
    data_input   = 8'h5A;
    anomaly_flag = 1'b1;
    report_valid = 1'b1;
    wait_accept("rst_mid", n);
    report_valid = 1'b0;
    for (int k = 1; k <= (2 + 4) * BC + 1; k++) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0 || report_accepted !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid async: serial_out=%b tx_busy=%b accepted=%b, required 1/0/0",
               serial_out, tx_busy, report_accepted);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) check_idle("rst_mid_after");
    send("rst_mid_next", DW'($urandom), 1'($urandom));
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) check_idle("rand_gap");
      send("random", DW'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_input_change();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/anomaly_report_tx.md
Name: anomaly_report_tx

Overview:
Serial transmitter for the anomaly detector's result path. It is the outbound counterpart of the serial-in sensor buffer. It accepts one parallel report, consisting of a sample word and its anomaly flag, using a valid/accepted handshake. It then shifts the report out on a single wire as a framed bit stream, for an off-chip logger or the next node.

Parameters:
DATA_WIDTH, 8, width of the sample word carried in each frame.
BIT_CYCLES, 4, clock cycles each serial bit is held on the line; legal range 1 and above.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
data_input  input  DATA_WIDTH  sample word to report; sampled only at acceptance.
anomaly_flag  input  1  anomaly result for data_input; sampled only at acceptance.
report_valid  input  1  producer has a report ready; held until report_accepted is seen.
report_accepted  output  1  one-cycle pulse confirming the report was latched.
serial_out  output  1  serial frame output; idles high.
tx_busy  output  1  high from the start bit through the last stop-bit cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: serial_out=1, tx_busy=0, report_accepted=0.
  - Internal: state=IDLE; bit counter, cycle counter and shift register cleared.
  - Reset asserted mid-frame aborts the frame immediately. The line returns high with no stop bit, and the aborted report is not retransmitted.
- States: IDLE, START, FLAG, DATA, PARITY (present only with the feature), STOP.
- IDLE:
  - serial_out=1, tx_busy=0.
  - At a rising edge where report_valid=1: latch data_input and anomaly_flag, then enter START.
  - In the following cycle: report_accepted=1 for exactly one cycle, serial_out=0, tx_busy=1.
- Bit timing:
  - Every bit is held exactly BIT_CYCLES cycles, counted by a cycle counter of width clog2(BIT_CYCLES), minimum 1 bit.
  - The state advances at the edge where the counter reaches BIT_CYCLES-1; the counter then wraps to 0.
- Frame order:
  - START bit = 0.
  - FLAG bit = the latched anomaly_flag.
  - DATA = DATA_WIDTH bits, LSB first, shifted out of the latched register. A bit index counter runs 0..DATA_WIDTH-1, and DATA exits after index DATA_WIDTH-1.
  - STOP bit = 1.
- Frame length without the feature: (DATA_WIDTH+3)*BIT_CYCLES cycles; 44 cycles at the defaults.
- STOP end: after the last STOP cycle, return to IDLE. IDLE lasts at least one cycle, so back-to-back reports have a period of frame length + 1 cycles.
- Handshake rules:
  - report_valid is ignored while tx_busy=1. A report held valid across a frame is accepted on the first IDLE cycle.
  - Changes to data_input or anomaly_flag after acceptance have no effect on the frame in flight.
  - Dropping report_valid before acceptance withdraws the report; nothing is sent.
- report_accepted never asserts on two consecutive cycles and never asserts while a frame is in progress. The only exception is its own cycle at the START of the frame.

Optional Feature:
Macro: ANOMALY_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. The parity bit is even parity over the flag bit and the DATA_WIDTH data bits, so the count of ones in flag+data+parity is even. Frame length becomes (DATA_WIDTH+4)*BIT_CYCLES; 48 cycles at the defaults.
- Undefined: no PARITY state and no parity logic; STOP directly follows the last data bit.

Test Plan:
1. Reset: assert reset for 3 cycles with report_valid=1 -> serial_out=1, tx_busy=0, report_accepted=0 throughout; no frame starts until reset is released.
2. Single frame, defaults: data_input=0xA5, anomaly_flag=1, report_valid pulsed high for 1 cycle in IDLE -> report_accepted high for 1 cycle. serial_out, in 4-cycle bits, = 0,1, 1,0,1,0,0,1,0,1, 1. tx_busy high for exactly 44 cycles.
3. Back-to-back: report_valid held high with 0x3C/flag 0, then 0xFF/flag 1 -> two report_accepted pulses 45 cycles apart. Line high for exactly 1 cycle between the frames; second frame bits = 0,1,1,1,1,1,1,1,1,1,1.
4. Input change mid-frame: accept 0x0F/flag 0, then set data_input=0xF0 and anomaly_flag=1 at cycle 10 -> transmitted bits remain 0,0,1,1,1,1,0,0,0,0,1.
5. Reset mid-frame: assert reset during the 5th data bit -> serial_out=1 and tx_busy=0 in the same cycle (asynchronous). After release, the next report produces a complete, correct frame.
6. With ANOMALY_TX_PARITY_EN: 0xA5 with flag 1 (5 ones) -> parity bit=1, frame 48 cycles. 0xA5 with flag 0 (4 ones) -> parity bit=0.
